ps2_keyboard: RTL and testbench
===============================

// Module: ps2_keyboard
// PURPOSE
//   Receives PS/2 device-to-host frames on PS2_CLK/PS2_DAT and buffers scancodes in a FIFO.
//   Presents the buffered scancodes to the CPU core through its I/O port read path:
//   data at port 60h, status at port 64h.
//   Sits upstream of the core in the de0 top level.
//   irq tells the core that scancodes are waiting.
// PARAMETERS
//   FIFO_LOG2  3      FIFO depth = 2**FIFO_LOG2 bytes (8)
//   FILTER     4      consecutive equal samples needed to accept a PS/2 line change
//   TIMEOUT    25000  clocks with no falling edge before a partial frame is abandoned (1 ms @25 MHz)
// PORTS
//   clock     in   1   system clock, 25 MHz (same as core)
//   reset     in   1   synchronous, active-high reset
//   ps2_clk   in   1   raw PS/2 clock line (asynchronous)
//   ps2_dat   in   1   raw PS/2 data line (asynchronous)
//   port_a    in   16  I/O port address from core (address[15:0])
//   pr        in   1   I/O read strobe, one clock per access
//   port_q    out  8   registered read data
//   irq       out  1   high while FIFO is non-empty
//   err       out  1   sticky frame/timeout error flag
// BEHAVIOUR
//   Reset values
//   - port_q=FFh, irq=0, err=0, ovf=0; FIFO empty; FSM in IDLE; bit counter=0; timeout counter=0.
//   - Reset mid-frame discards the partial frame. FIFO contents are lost.
//   Input conditioning
//   - Both lines pass through a 2-flop synchronizer, then a filter.
//   - The filtered value changes only after FILTER consecutive identical synced samples.
//   - fall = filtered clk goes 1->0. All frame sampling uses the filtered data line at fall.
//   FSM (advances only on fall)
//   - IDLE:   dat=0 -> DATA, bitcnt=0. dat=1 -> stay (spurious edge ignored).
//   - DATA:   shift dat in LSB-first. After the 8th bit -> PARITY.
//   - PARITY: latch dat -> STOP.
//   - STOP:   if dat=1 and (data ^ parity) has odd parity, push the byte; otherwise set err.
//             -> IDLE in both cases.
//   Timeout
//   - The counter clears on every fall and while in IDLE; otherwise it increments.
//   - At TIMEOUT-1: FSM -> IDLE, err=1, nothing pushed.
//   FIFO
//   - Depth 2**FIFO_LOG2, with head/tail pointers wrapping modulo depth and a count of width FIFO_LOG2+1.
//   - Push when full: byte dropped, ovf=1.
//   - Push and pop in the same clock: both take effect and the count is unchanged.
//     When the FIFO is empty, the pop is a no-op and the push still succeeds.
//   - irq = (count != 0), registered. It updates one clock after the push or pop.
//   Port reads (decoded only when pr=1; port_q updates at the next clock edge, latency 1)
//   - 0060h: port_q = head byte, then pop. When the FIFO is empty, port_q=00h and nothing pops.
//   - 0064h: port_q = {5'b0, ovf, err, count!=0}.
//     err and ovf clear in the same clock, unless a new error or overflow arises in that clock.
//     A new error or overflow wins.
//   - Any other address: port_q = FFh.
//   - pr=0: port_q holds its previous value.
//   - err output mirrors the internal sticky err bit.
//   Host-to-device transmission is not supported; the lines are only sampled, never driven.
// TESTING
//   1. Frame 1Ch with parity=0 and stop=1 -> irq=1. Read 60h -> port_q=1Ch. irq=0 next clock.
//      Read 64h -> 00h.
//   2. Frame 1Ch with parity=1 -> no push, irq stays 0. Read 64h -> 02h, then read 64h again -> 00h.
//   3. Nine valid frames 01h..09h (depth 8) -> read 64h gives 05h.
//      Eight reads of 60h return 01h..08h in order. A ninth read of 60h returns 00h.
//   4. Start bit plus 4 data bits, then clock held high for TIMEOUT+10 cycles, then a valid frame F0h
//      -> err=1, read 60h returns F0h, FIFO held exactly one byte.
//   5. 2-clock low glitch on ps2_clk (FILTER=4) inside a valid frame E0h -> E0h received intact, err=0.
//   6. FIFO count=1: assert pr@60h in the same clock the STOP bit of frame 2Ah is accepted
//      -> old byte returned, count stays 1, next read returns 2Ah.
//   7. reset pulsed after the 5th data bit, followed by a valid frame 5Ah -> only 5Ah is in the FIFO, err=0.

Source files
------------

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: conditions the raw PS/2 lines, deframes device-to-host
// bytes and buffers them in a small FIFO read by the core through ports 60h/64h.
module ps2_keyboard #(
    parameter int FIFO_LOG2 = 3,
    parameter int FILTER    = 4,
    parameter int TIMEOUT   = 25000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    input  logic [15:0] port_a,
    input  logic        pr,
    output logic [7:0]  port_q,
    output logic        irq,
    output logic        err
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int FW    = $clog2(FILTER + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int CW    = FIFO_LOG2 + 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // synchronizers and filters
    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          clk_f_q, dat_f_q, clk_prev_q;
    logic [FW-1:0] clk_fcnt_q, dat_fcnt_q;
    logic          fall;

    // frame FSM
    state_t        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          push, frame_err;

    // FIFO and port interface
    logic [7:0]           mem_q [DEPTH];
    logic [FIFO_LOG2-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 err_q, err_d, ovf_q, ovf_d, irq_q;
    logic [7:0]           port_q_q, port_q_d;
    logic                 rd_data, rd_stat, pop, wr, full;

    // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filters: a line only flips after FILTER consecutive differing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_f_q    <= 1'b1;
            dat_f_q    <= 1'b1;
            clk_prev_q <= 1'b1;
            clk_fcnt_q <= '0;
            dat_fcnt_q <= '0;
        end else begin
            clk_prev_q <= clk_f_q;
            if (clk_s2_q == clk_f_q) begin
                clk_fcnt_q <= '0;
            end else if (clk_fcnt_q == FW'(FILTER - 1)) begin
                clk_f_q    <= clk_s2_q;
                clk_fcnt_q <= '0;
            end else begin
                clk_fcnt_q <= clk_fcnt_q + 1'b1;
            end
            if (dat_s2_q == dat_f_q) begin
                dat_fcnt_q <= '0;
            end else if (dat_fcnt_q == FW'(FILTER - 1)) begin
                dat_f_q    <= dat_s2_q;
                dat_fcnt_q <= '0;
            end else begin
                dat_fcnt_q <= dat_fcnt_q + 1'b1;
            end
        end
    end

    assign fall = clk_prev_q & ~clk_f_q;

    // Frame FSM state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tcnt_q   <= tcnt_d;
        end
    end

    // Frame FSM next state: steps on each filtered falling clock edge; an
    // edge wins over a timeout landing in the same clock.
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        push      = 1'b0;
        frame_err = 1'b0;
        tcnt_d    = (state_q == S_IDLE || fall) ? '0 : tcnt_q + 1'b1;
        if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!dat_f_q) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d = {dat_f_q, shift_q[7:1]};
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                    else                  bitcnt_d = bitcnt_q + 1'b1;
                end
                S_PARITY: begin
                    par_d   = dat_f_q;
                    state_d = S_STOP;
                end
                default: begin
                    if (dat_f_q && (^{shift_q, par_q})) push = 1'b1;
                    else                                frame_err = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q != S_IDLE && tcnt_q == TW'(TIMEOUT - 1)) begin
            state_d   = S_IDLE;
            frame_err = 1'b1;
            tcnt_d    = '0;
        end
    end

    // FIFO bookkeeping and port read decode. A push into a full FIFO is
    // still accepted when a pop frees a slot in the same clock.
    always_comb begin
        rd_data  = pr && (port_a == 16'h0060);
        rd_stat  = pr && (port_a == 16'h0064);
        full     = (count_q == CW'(DEPTH));
        pop      = rd_data && (count_q != '0);
        wr       = push && (!full || pop);
        head_d   = pop ? head_q + 1'b1 : head_q;
        tail_d   = wr  ? tail_q + 1'b1 : tail_q;
        count_d  = count_q;
        if (wr && !pop)      count_d = count_q + 1'b1;
        else if (!wr && pop) count_d = count_q - 1'b1;
        err_d    = (err_q & ~rd_stat) | frame_err;
        ovf_d    = (ovf_q & ~rd_stat) | (push & ~wr);
        port_q_d = port_q_q;
        if (rd_data)      port_q_d = (count_q != '0) ? mem_q[head_q] : 8'h00;
        else if (rd_stat) port_q_d = {5'b0, ovf_q, err_q, count_q != '0};
        else if (pr)      port_q_d = 8'hFF;
    end

    // FIFO, flags and read data registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
            port_q_q <= 8'hFF;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            irq_q    <= (count_d != '0);
            port_q_q <= port_q_d;
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clock) begin
        if (wr) mem_q[tail_q] <= shift_q;
    end

    assign port_q = port_q_q;
    assign irq    = irq_q;
    assign err    = err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: drives PS/2 frames bit by bit and checks the
// port 60h/64h read path, irq and err.
module tb_ps2_keyboard;

    localparam int HALF = 10;      // system clocks per PS/2 half period
    localparam int TOUT = 25000;
    localparam int STOP_LAT = 6;   // 2 sync + FILTER clocks from line low to fall

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [15:0] port_a = 16'h0000;
    logic        pr = 1'b0;
    logic [7:0]  port_q;
    logic        irq, err;

    int checks = 0;
    int failures = 0;

    always #20 clock = ~clock;

    ps2_keyboard dut (
        .clock  (clock),
        .reset  (reset),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .port_a (port_a),
        .pr     (pr),
        .port_q (port_q),
        .irq    (irq),
        .err    (err)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One PS/2 bit: data set while clock high, then a low pulse. Optional
    // 2-clock low glitch during the high phase.
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_dat = b;
        if (glitch) begin
            tick(3);
            ps2_clk = 1'b0;
            tick(2);
            ps2_clk = 1'b1;
            tick(HALF - 5);
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic ps2_frame(input logic [7:0] d, input bit bad_par, input int glitch_bit);
        logic [10:0] f;
        f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(f[i], i == glitch_bit);
        tick(HALF);
    endtask

    task automatic rd(input logic [15:0] a);
        port_a = a;
        pr = 1'b1;
        tick(1);
        pr = 1'b0;
        port_a = 16'h0000;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        checks++; if (port_q !== 8'hFF) begin failures++; $display("FAIL reset_port_q got=%h exp=ff", port_q); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_port_misc;
        rd(16'h0064);
        checks++; if (port_q !== 8'h00) begin failures++; $display("FAIL misc_stat got=%h exp=00", port_q); end
        tick(3);
        checks++; if (port_q !== 8'h00) begin failures++; $display("FAIL misc_hold got=%h exp=00", port_q); end
        rd(16'h0061);
        checks++; if (port_q !== 8'hFF) begin failures++; $display("FAIL misc_other_addr got=%h exp=ff", port_q); end
        rd(16'h0160);
        checks++; if (port_q !== 8'hFF) begin failures++; $display("FAIL misc_upper_addr got=%h exp=ff", port_q); end
    endtask

    task automatic test_valid_frame;
        ps2_frame(8'h1C, 1'b0, -1);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL valid_irq got=%b exp=1", irq); end
        rd(16'h0060);
        checks++; if (port_q !== 8'h1C) begin failures++; $display("FAIL valid_data got=%h exp=1c", port_q); end
        tick(1);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL valid_irq_clear got=%b exp=0", irq); end
        rd(16'h0064);
        checks++; if (port_q !== 8'h00) begin failures++; $display("FAIL valid_stat got=%h exp=00", port_q); end
    endtask

    task automatic test_parity_error;
        ps2_frame(8'h1C, 1'b1, -1);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL par_irq got=%b exp=0", irq); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL par_err got=%b exp=1", err); end
        rd(16'h0064);
        checks++; if (port_q !== 8'h02) begin failures++; $display("FAIL par_stat1 got=%h exp=02", port_q); end
        rd(16'h0064);
        checks++; if (port_q !== 8'h00) begin failures++; $display("FAIL par_stat2 got=%h exp=00", port_q); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL par_err_clear got=%b exp=0", err); end
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 9; i++) ps2_frame(8'(i), 1'b0, -1);
        rd(16'h0064);
        checks++; if (port_q !== 8'h05) begin failures++; $display("FAIL ovf_stat got=%h exp=05", port_q); end
        for (int i = 1; i <= 8; i++) begin
            rd(16'h0060);
            checks++; if (port_q !== 8'(i)) begin failures++; $display("FAIL ovf_read%0d got=%h exp=%h", i, port_q, 8'(i)); end
        end
        rd(16'h0060);
        checks++; if (port_q !== 8'h00) begin failures++; $display("FAIL ovf_read_empty got=%h exp=00", port_q); end
        rd(16'h0064);
        checks++; if (port_q !== 8'h00) begin failures++; $display("FAIL ovf_stat_clear got=%h exp=00", port_q); end
    endtask

    task automatic test_timeout;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
        tick(TOUT + 10);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL tout_err got=%b exp=1", err); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL tout_irq got=%b exp=0", irq); end
        ps2_frame(8'hF0, 1'b0, -1);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL tout_err_sticky got=%b exp=1", err); end
        rd(16'h0060);
        checks++; if (port_q !== 8'hF0) begin failures++; $display("FAIL tout_data got=%h exp=f0", port_q); end
        rd(16'h0060);
        checks++; if (port_q !== 8'h00) begin failures++; $display("FAIL tout_one_byte got=%h exp=00", port_q); end
        rd(16'h0064);
        checks++; if (port_q !== 8'h02) begin failures++; $display("FAIL tout_stat got=%h exp=02", port_q); end
    endtask

    task automatic test_glitch;
        ps2_frame(8'hE0, 1'b0, 4);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL glitch_err got=%b exp=0", err); end
        rd(16'h0060);
        checks++; if (port_q !== 8'hE0) begin failures++; $display("FAIL glitch_data got=%h exp=e0", port_q); end
        rd(16'h0064);
        checks++; if (port_q !== 8'h00) begin failures++; $display("FAIL glitch_stat got=%h exp=00", port_q); end
    endtask

    // Pop of the old byte lands in the same clock as the push of 2Ah.
    task automatic test_back_to_back;
        logic [10:0] f;
        ps2_frame(8'h11, 1'b0, -1);
        f = {1'b1, ~^8'h2A, 8'h2A, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(f[i], 1'b0);
        ps2_dat = 1'b1;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(STOP_LAT);
        port_a = 16'h0060;
        pr = 1'b1;
        tick(1);
        pr = 1'b0;
        port_a = 16'h0000;
        checks++; if (port_q !== 8'h11) begin failures++; $display("FAIL b2b_old got=%h exp=11", port_q); end
        tick(HALF - STOP_LAT - 1);
        ps2_clk = 1'b1;
        tick(HALF);
        rd(16'h0064);
        checks++; if (port_q !== 8'h01) begin failures++; $display("FAIL b2b_count got=%h exp=01", port_q); end
        rd(16'h0060);
        checks++; if (port_q !== 8'h2A) begin failures++; $display("FAIL b2b_new got=%h exp=2a", port_q); end
        rd(16'h0060);
        checks++; if (port_q !== 8'h00) begin failures++; $display("FAIL b2b_empty got=%h exp=00", port_q); end
    endtask

    task automatic test_reset_midframe;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(i[0], 1'b0);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        checks++; if (port_q !== 8'hFF) begin failures++; $display("FAIL rstmid_port_q got=%h exp=ff", port_q); end
        ps2_frame(8'h5A, 1'b0, -1);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rstmid_err got=%b exp=0", err); end
        rd(16'h0064);
        checks++; if (port_q !== 8'h01) begin failures++; $display("FAIL rstmid_stat got=%h exp=01", port_q); end
        rd(16'h0060);
        checks++; if (port_q !== 8'h5A) begin failures++; $display("FAIL rstmid_data got=%h exp=5a", port_q); end
        rd(16'h0060);
        checks++; if (port_q !== 8'h00) begin failures++; $display("FAIL rstmid_empty got=%h exp=00", port_q); end
    endtask

    initial begin
        test_reset;
        test_port_misc;
        test_valid_frame;
        test_parity_error;
        test_overflow;
        test_timeout;
        test_glitch;
        test_back_to_back;
        test_reset_midframe;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
